// File: rtl/letc_core_pkg.sv
// LETC Core execute-stage types and constants shared by the multiply unit.
package letc_core_pkg;

   // Encoding matches funct3[1:0] of the M-extension multiply group.
   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   localparam int MUL_LATENCY = 5;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mul_unit_state_e;

   function automatic logic rs1_is_signed(input mul_op_e op);
      return (op == MULH) || (op == MULHSU);
   endfunction

   function automatic logic rs2_is_signed(input mul_op_e op);
      return op == MULH;
   endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Shared RISC-V base types for the LETC Core.
package riscv_pkg;

   typedef logic [31:0] word_t;

endpackage

// File: rtl/letc_core_multiplier.sv
// Unsigned 32x32->64 multiplier, MUL_LATENCY register stages from i_valid to o_valid.
module letc_core_multiplier
   import letc_core_pkg::*;
   import riscv_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_valid,
   input  word_t i_a,
   input  word_t i_b,
   output logic  o_valid,
   output word_t o_upper,
   output word_t o_lower
);

   logic [MUL_LATENCY-1:0] valid_q;
   word_t                  a_q;
   word_t                  b_q;
   logic [63:0]            prod_q [MUL_LATENCY-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) valid_q <= '0;
      else       valid_q <= {valid_q[MUL_LATENCY-2:0], i_valid};
   end

   // Data stages carry no reset; consumers time completion independently.
   always_ff @(posedge i_clk) begin
      if (i_valid) begin
         a_q <= i_a;
         b_q <= i_b;
      end
      prod_q[0] <= 64'(a_q) * 64'(b_q);
      for (int i = 1; i < MUL_LATENCY - 1; i++) begin
         prod_q[i] <= prod_q[i-1];
      end
   end

   assign o_valid = valid_q[MUL_LATENCY-1];
   assign o_upper = prod_q[MUL_LATENCY-2][63:32];
   assign o_lower = prod_q[MUL_LATENCY-2][31:0];

endmodule

// File: rtl/letc_core_mul_unit.sv
// RISC-V M-extension multiply front-end: sign handling around an unsigned pipelined multiplier.
// Optional LETC_CORE_MUL_ZERO_BYPASS_EN: zero operands complete in one cycle without the multiplier.
module letc_core_mul_unit
   import letc_core_pkg::*;
   import riscv_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst,
   input  logic    i_req_valid,
   output logic    o_req_ready,
   input  mul_op_e i_req_op,
   input  word_t   i_req_rs1,
   input  word_t   i_req_rs2,
   input  logic    i_flush,
   output logic    o_rsp_valid,
   input  logic    i_rsp_ready,
   output word_t   o_rsp_result
);

   mul_unit_state_e state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   mul_op_e         op_q, op_d;
   logic            neg_q, neg_d;
   word_t           result_q, result_d;

   logic        accept;
   logic        bypass;
   logic        mul_start;
   logic        sign_rs1, sign_rs2;
   word_t       mag_rs1, mag_rs2;
   word_t       mul_upper, mul_lower;
   logic        mul_valid_unused;
   logic [63:0] product;

   // Handshakes: a transfer occurs on a cycle where valid && ready; the
   // request side is only ready in IDLE and never while flushing.
   assign o_req_ready = (state_q == IDLE) && !i_flush;
   assign o_rsp_valid = (state_q == DONE);
   assign o_rsp_result = result_q;
   assign accept = i_req_valid && o_req_ready;

   assign sign_rs1 = i_req_rs1[31] && rs1_is_signed(i_req_op);
   assign sign_rs2 = i_req_rs2[31] && rs2_is_signed(i_req_op);
   assign mag_rs1  = sign_rs1 ? -i_req_rs1 : i_req_rs1;
   assign mag_rs2  = sign_rs2 ? -i_req_rs2 : i_req_rs2;

`ifdef LETC_CORE_MUL_ZERO_BYPASS_EN
   assign bypass = (i_req_rs1 == '0) || (i_req_rs2 == '0);
`else
   assign bypass = 1'b0;
`endif

   assign mul_start = accept && !bypass;
   assign product   = neg_q ? -{mul_upper, mul_lower} : {mul_upper, mul_lower};

   letc_core_multiplier u_multiplier (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (mul_start),
      .i_a     (mag_rs1),
      .i_b     (mag_rs2),
      .o_valid (mul_valid_unused),
      .o_upper (mul_upper),
      .o_lower (mul_lower)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      if (i_flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  op_d  = i_req_op;
                  neg_d = sign_rs1 ^ sign_rs2;
                  if (bypass) begin
                     state_d  = DONE;
                     result_d = '0;
                  end else begin
                     state_d = BUSY;
                     cnt_d   = 3'(MUL_LATENCY - 1);
                  end
               end
            end
            BUSY: begin
               // Countdown is aligned so cnt_q == 0 is the cycle this op's product leaves the pipe.
               if (cnt_q == '0) begin
                  state_d  = DONE;
                  result_d = (op_q == MUL) ? product[31:0] : product[63:32];
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            DONE: begin
               if (i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= MUL;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

endmodule
